// File: rtl/heater_pkg.sv
// Shared definitions for the heater partition scheduler: FSM encoding,
// config word layout and small arithmetic helpers.
package heater_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAT  = 2'd1,
        ST_COOL  = 2'd2,
        ST_FAULT = 2'd3
    } heater_state_t;

    localparam int DUTY_LSB  = 0;
    localparam int DUTY_W    = 8;
    localparam int LIMIT_LSB = 8;
    localparam int LIMIT_W   = 12;
    localparam int MASK_LSB  = 20;
    localparam int MASK_W    = 8;
    localparam int EN_BIT    = 28;

    typedef struct packed {
        logic [DUTY_W-1:0]  duty;
        logic [LIMIT_W-1:0] limit;
        logic [MASK_W-1:0]  mask;
    } heater_cfg_t;

    function automatic heater_cfg_t unpackCfg(input logic [31:0] data);
        heater_cfg_t cfg;
        cfg.duty  = data[DUTY_LSB +: DUTY_W];
        cfg.limit = data[LIMIT_LSB +: LIMIT_W];
        cfg.mask  = data[MASK_LSB +: MASK_W];
        return cfg;
    endfunction

    // Unsigned subtraction clamped at zero, used for the hysteresis threshold.
    function automatic logic [LIMIT_W-1:0] satSub(input logic [LIMIT_W-1:0] a,
                                                  input logic [LIMIT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/heater_pwm_tick.sv
// PWM timebase: a prescaler feeding an 8-bit tick counter. Both counters are
// held at zero while not running so every heating session starts on a fresh period.
module heater_pwm_tick #(
    parameter int PRESCALE = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    output logic [7:0] o_tick_cnt,
    output logic       o_period_wrap
);

    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0] r_prescale;
    logic [7:0]      r_tick_cnt;
    logic            w_ps_wrap;

    assign w_ps_wrap     = i_run && (r_prescale == PS_W'(PRESCALE - 1));
    assign o_period_wrap = w_ps_wrap && (r_tick_cnt == 8'hFF);
    assign o_tick_cnt    = r_tick_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_run) begin
            r_prescale <= '0;
            r_tick_cnt <= '0;
        end else if (w_ps_wrap) begin
            r_prescale <= '0;
            r_tick_cnt <= r_tick_cnt + 8'd1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

endmodule

// File: rtl/heater_sched.sv
// Heater partition scheduler: double-buffered config, IDLE/HEAT/COOL/FAULT
// sequencing with hysteresis, sample watchdog and registered bank enables.
module heater_sched import heater_pkg::*; #(
    parameter int NUM_BANKS   = 8,
    parameter int PRESCALE    = 1024,
    parameter int HYST        = 16,
    parameter int WDOG_CYCLES = 2**20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cfg_wr,
    input  logic [31:0]          i_cfg_data,
    input  logic                 i_temp_valid,
    input  logic [11:0]          i_temp_data,
    output logic [NUM_BANKS-1:0] o_heater_en,
    output logic [1:0]           o_state,
    output logic                 o_overtemp,
    output logic [15:0]          o_period_cnt
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    heater_state_t       r_state;
    heater_state_t       w_state_next;
    heater_cfg_t         r_shadow;
    heater_cfg_t         r_active;
    heater_cfg_t         w_cfg_in;
    logic                r_enable;
    logic                w_enable;
    logic [WD_W-1:0]     r_wdog;
    logic                w_wdog_expire;
    logic                w_run;
    logic [7:0]          w_tick_cnt;
    logic                w_period_wrap;
    logic [11:0]         w_resume_lim;
    logic                w_cool_exit;
    logic [NUM_BANKS-1:0] r_heater_en;
    logic [NUM_BANKS-1:0] w_heater_en_next;
    logic                r_overtemp;
    logic                w_overtemp_next;
    logic [15:0]         r_period_cnt;
    logic                w_unused_cfg;

    assign w_cfg_in     = unpackCfg(i_cfg_data);
    assign w_unused_cfg = ^i_cfg_data[31:29];
    assign w_run        = (r_state == ST_HEAT) || (r_state == ST_COOL);

    // A disabling write takes effect on the edge that captures it, so it
    // outranks any temperature event arriving in the same cycle.
    assign w_enable = i_cfg_wr ? i_cfg_data[EN_BIT] : r_enable;

    // A saturated threshold of zero can never be undercut, so code 0 resumes.
    assign w_resume_lim  = satSub(r_active.limit, 12'(HYST));
    assign w_cool_exit   = (w_resume_lim == '0) ? (i_temp_data == '0)
                                                : (i_temp_data < w_resume_lim);
    assign w_wdog_expire = (r_wdog >= WD_W'(WDOG_CYCLES - 1));

    heater_pwm_tick #(
        .PRESCALE (PRESCALE)
    ) u_pwm_tick (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_run         (w_run),
        .o_tick_cnt    (w_tick_cnt),
        .o_period_wrap (w_period_wrap)
    );

    // Active settings only change on a period boundary while running.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_enable <= 1'b0;
        end else begin
            if (i_cfg_wr) begin
                r_shadow <= w_cfg_in;
                r_enable <= i_cfg_data[EN_BIT];
            end
            if (!w_run) begin
                r_active <= i_cfg_wr ? w_cfg_in : r_shadow;
            end else if (w_period_wrap) begin
                r_active <= r_shadow;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_temp_valid || !w_run) begin
            r_wdog <= '0;
        end else if (r_wdog != WD_W'(WDOG_CYCLES)) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_temp_valid) begin
                        w_state_next = (i_temp_data < r_active.limit) ? ST_HEAT : ST_COOL;
                    end
                end
                ST_HEAT: begin
                    if (i_temp_valid) begin
                        if (i_temp_data >= r_active.limit) begin
                            w_state_next = ST_COOL;
                        end
                    end else if (w_wdog_expire) begin
                        w_state_next = ST_FAULT;
                    end
                end
                ST_COOL: begin
                    if (i_temp_valid) begin
                        if (w_cool_exit) begin
                            w_state_next = ST_HEAT;
                        end
                    end else if (w_wdog_expire) begin
                        w_state_next = ST_FAULT;
                    end
                end
                default: w_state_next = ST_FAULT;
            endcase
        end
    end

    // Banks switch off on the same edge that leaves HEAT; on entry they wait
    // one cycle so the enable always trails the tick count it reflects.
    always_comb begin
        w_heater_en_next = '0;
        w_overtemp_next  = (w_state_next == ST_COOL);
        if ((r_state == ST_HEAT) && (w_state_next == ST_HEAT) &&
            (w_tick_cnt < r_active.duty)) begin
            w_heater_en_next = r_active.mask[NUM_BANKS-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_heater_en  <= '0;
            r_overtemp   <= 1'b0;
            r_period_cnt <= '0;
        end else begin
            r_heater_en <= w_heater_en_next;
            r_overtemp  <= w_overtemp_next;
            if (w_period_wrap) begin
                r_period_cnt <= r_period_cnt + 16'd1;
            end
        end
    end

    assign o_heater_en  = r_heater_en;
    assign o_state      = r_state;
    assign o_overtemp   = r_overtemp;
    assign o_period_cnt = r_period_cnt;

endmodule

// File: tb/tb_heater_sched.sv
// Scoreboard bench for heater_sched: stimulus schedules expected outputs for
// specific cycles, a negedge monitor compares them as those cycles arrive.
module tb_heater_sched;

    localparam int NUM_BANKS   = 8;
    localparam int PRESCALE    = 4;
    localparam int HYST        = 16;
    localparam int WDOG_CYCLES = 64;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HEAT  = 2'd1;
    localparam logic [1:0] S_COOL  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfgWr;
    logic [31:0] cfgData;
    logic        tempValid;
    logic [11:0] tempData;
    logic [7:0]  heaterEn;
    logic [1:0]  state;
    logic        overtemp;
    logic [15:0] periodCnt;

    int          cycle = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic        keepAlive = 1'b0;
    logic [11:0] keepTemp = '0;

    typedef struct {
        int          cyc;
        string       name;
        logic [7:0]  en;
        logic [1:0]  st;
        logic        ovt;
        bit          chkPc;
        logic [15:0] pc;
    } expect_t;

    expect_t sbq[$];

    heater_sched #(
        .NUM_BANKS   (NUM_BANKS),
        .PRESCALE    (PRESCALE),
        .HYST        (HYST),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cfg_wr     (cfgWr),
        .i_cfg_data   (cfgData),
        .i_temp_valid (tempValid),
        .i_temp_data  (tempData),
        .o_heater_en  (heaterEn),
        .o_state      (state),
        .o_overtemp   (overtemp),
        .o_period_cnt (periodCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] cfgWord(input int duty, input int limit,
                                            input int mask, input bit en);
        logic [31:0] w;
        w = {3'b000, en, 8'(mask), 12'(limit), 8'(duty)};
        return w;
    endfunction

    // Expected bank enables at edge x for a session that entered HEAT at edge base.
    function automatic logic [7:0] enModel(input int x, input int base,
                                           input int duty, input int mask);
        int tick;
        tick = ((x - base - 1) / PRESCALE) % 256;
        return (tick < duty) ? 8'(mask) : 8'h00;
    endfunction

    task automatic pushExpect(input string name, input int cyc, input logic [7:0] en,
                              input logic [1:0] st, input logic ovt,
                              input bit chkPc, input logic [15:0] pc);
        expect_t ex;
        int idx;
        if (cyc <= cycle) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s scheduled for past cycle %0d (now %0d)", name, cyc, cycle);
        end else begin
            ex.cyc = cyc; ex.name = name; ex.en = en; ex.st = st;
            ex.ovt = ovt; ex.chkPc = chkPc; ex.pc = pc;
            idx = sbq.size();
            while (idx > 0 && sbq[idx-1].cyc > cyc) idx--;
            sbq.insert(idx, ex);
        end
    endtask

    task automatic checkOutput(input expect_t ex);
        bit bad;
        testsRun++;
        bad = (heaterEn !== ex.en) || (state !== ex.st) || (overtemp !== ex.ovt) ||
              (ex.chkPc && (periodCnt !== ex.pc));
        if (bad) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle=%0d got en=%02h st=%0d ovt=%0b pc=%0d want en=%02h st=%0d ovt=%0b pc=%0d(chk=%0d)",
                     ex.name, cycle, heaterEn, state, overtemp, periodCnt,
                     ex.en, ex.st, ex.ovt, ex.pc, ex.chkPc);
        end
    endtask

    always @(negedge clk) begin
        expect_t ex;
        while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
            ex = sbq.pop_front();
            checkOutput(ex);
        end
    end

    task automatic applyStimulus(input logic w, input logic [31:0] d,
                                 input logic tv, input logic [11:0] td);
        cfgWr = w; cfgData = d; tempValid = tv; tempData = td;
        @(negedge clk);
        cfgWr = 1'b0; tempValid = 1'b0;
    endtask

    task automatic pulseTemp(input logic [11:0] t);
        applyStimulus(1'b0, cfgData, 1'b1, t);
    endtask

    task automatic cfgWrite(input int duty, input int limit, input int mask, input bit en);
        applyStimulus(1'b1, cfgWord(duty, limit, mask, en), 1'b0, tempData);
    endtask

    task automatic idleFor(input int n);
        for (int i = 0; i < n; i++) begin
            if (keepAlive && (cycle % 16 == 0)) pulseTemp(keepTemp);
            else @(negedge clk);
        end
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("[TB] FAIL timeout: bench did not complete within cycle budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int e, c, h, p, d, s, r, e2, e3, h6, x;
        expect_t ex;
        reset = 1'b1; cfgWr = 1'b0; cfgData = '0; tempValid = 1'b0; tempData = '0;
        repeat (3) @(negedge clk);
        pushExpect("reset", cycle + 1, 8'h00, S_IDLE, 1'b0, 1'b1, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic PWM: duty 64 of 256 ticks, four clocks per tick.
        cfgWrite(64, 12'h800, 8'hFF, 1'b1);
        idleFor(2);
        e = cycle + 1;
        pushExpect("enterHeat",   e,        8'h00, S_HEAT, 1'b0, 1'b1, 16'd0);
        pushExpect("pwmFirstOn",  e + 1,    8'hFF, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("pwmLastOn",   e + 256,  8'hFF, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("pwmFirstOff", e + 257,  8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("prePeriod",   e + 1023, 8'h00, S_HEAT, 1'b0, 1'b1, 16'd0);
        pushExpect("periodCount", e + 1024, 8'h00, S_HEAT, 1'b0, 1'b1, 16'd1);
        pushExpect("period2On",   e + 1025, 8'hFF, S_HEAT, 1'b0, 1'b0, 16'd0);
        pulseTemp(12'h700);
        keepAlive = 1'b1; keepTemp = 12'h700;
        idleFor(e + 1100 - cycle);

        // Overtemp and hysteresis around limit 0x800 (resume below 0x7F0).
        c = cycle + 2;
        pushExpect("heatBeforeCool", c - 1, enModel(c - 1, e, 64, 8'hFF), S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("heatToCool",     c,     8'h00, S_COOL, 1'b1, 1'b0, 16'd0);
        idleFor(1);
        pulseTemp(12'h800);
        keepTemp = 12'h900;
        idleFor(3);
        x = cycle + 1;
        pushExpect("coolHold", x, 8'h00, S_COOL, 1'b1, 1'b0, 16'd0);
        pulseTemp(12'h7F5);
        idleFor(3);
        h = cycle + 1;
        pushExpect("coolToHeat", h,     8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("pwmResume",  h + 1, enModel(h + 1, e, 64, 8'hFF), S_HEAT, 1'b0, 1'b0, 16'd0);
        pulseTemp(12'h7EF);
        keepTemp = 12'h700;

        // Mid-period reconfiguration waits for the period boundary.
        cfgWrite(128, 12'h800, 8'h0F, 1'b1);
        pushExpect("oldDutyHold", e + 1280, 8'hFF, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("oldDutyEnd",  e + 1281, 8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("wrapCount2",  e + 2048, 8'h00, S_HEAT, 1'b0, 1'b1, 16'd2);
        pushExpect("newMaskOn",   e + 2049, 8'h0F, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("newDutyLast", e + 2560, 8'h0F, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("newDutyOff",  e + 2561, 8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        idleFor(e + 2570 - cycle);

        // Sensor loss: 64 clocks without a sample forces a sticky fault.
        p = cycle + 1;
        pulseTemp(12'h700);
        keepAlive = 1'b0;
        pushExpect("preFault",  p + 63, enModel(p + 63, e, 128, 8'h0F), S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("wdogFault", p + 64, 8'h00, S_FAULT, 1'b0, 1'b0, 16'd0);
        idleFor(70);
        x = cycle + 1;
        pushExpect("faultSticky", x, 8'h00, S_FAULT, 1'b0, 1'b0, 16'd0);
        pulseTemp(12'h100);
        idleFor(2);
        d = cycle + 1;
        pushExpect("faultExit", d, 8'h00, S_IDLE, 1'b0, 1'b0, 16'd0);
        cfgWrite(128, 12'h800, 8'h0F, 1'b0);

        // Sample on the expiry cycle wins, then disable beats an overtemp sample.
        idleFor(2);
        cfgWrite(64, 12'h800, 8'hFF, 1'b1);
        idleFor(2);
        e2 = cycle + 1;
        pushExpect("reenterHeat", e2, 8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pulseTemp(12'h700);
        idleFor(63);
        x = cycle + 1;
        pushExpect("tempBeatsWdog", x, enModel(x, e2, 64, 8'hFF), S_HEAT, 1'b0, 1'b0, 16'd0);
        pulseTemp(12'h700);
        s = cycle + 1;
        pushExpect("disableBeatsOvt", s, 8'h00, S_IDLE, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b1, cfgWord(64, 12'h800, 8'hFF, 1'b0), 1'b1, 12'h900);

        // Reset in the middle of a heating session with a pending shadow write.
        idleFor(2);
        cfgWrite(64, 12'h800, 8'hFF, 1'b1);
        idleFor(2);
        e3 = cycle + 1;
        pulseTemp(12'h700);
        cfgWrite(200, 12'h800, 8'hFF, 1'b1);
        idleFor(10);
        r = cycle + 2;
        pushExpect("preReset", r - 1, enModel(r - 1, e3, 64, 8'hFF), S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("resetMid", r,     8'h00, S_IDLE, 1'b0, 1'b1, 16'd0);
        idleFor(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Limit below the hysteresis: only code 0 resumes; duty 0 never drives banks.
        idleFor(2);
        cfgWrite(0, 8, 8'hFF, 1'b1);
        idleFor(2);
        x = cycle + 1;
        pushExpect("idleToCool", x, 8'h00, S_COOL, 1'b1, 1'b0, 16'd0);
        pulseTemp(12'h010);
        idleFor(2);
        x = cycle + 1;
        pushExpect("lowLimitHold", x, 8'h00, S_COOL, 1'b1, 1'b0, 16'd0);
        pulseTemp(12'h001);
        idleFor(2);
        h6 = cycle + 1;
        pushExpect("lowLimitResume", h6,       8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("dutyZeroA",      h6 + 1,   8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("dutyZeroB",      h6 + 5,   8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pushExpect("dutyZeroC",      h6 + 100, 8'h00, S_HEAT, 1'b0, 1'b0, 16'd0);
        pulseTemp(12'h000);
        keepAlive = 1'b1; keepTemp = 12'h000;
        idleFor(110);
        keepAlive = 1'b0;

        for (int i = 0; i < 60 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        while (sbq.size() > 0) begin
            ex = sbq.pop_front();
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s never checked (due cycle %0d, now %0d)", ex.name, ex.cyc, cycle);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
